// File: rtl/mfp_row_window_pkg.sv
// Shared MFP definitions for the row-window slice.
// Holds the row-window state encoding and a small helper used to size
// the border logic. Pixels are carried as raw two's-complement bit
// vectors; nothing here performs arithmetic on them.
package mfp_row_window_pkg;

  // Row-window sequencer states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } row_state_e;

  // Half window length: pixels needed on each side of the centre.
  function automatic int half_len(input int arr_l);
    return arr_l / 2;
  endfunction

endpackage

// File: rtl/mfp_window_shreg.sv
// ArrL-deep pixel shift register with left-border load and right-border
// replicate.
//   clk, aclr  : clock, asynchronous active-high clear
//   load_all   : write din into every element (pixel 0 of a row)
//   shift      : shift toward element 0; the new pixel enters element ArrL-1
//   replicate  : with shift, re-insert the newest element instead of din
//   din        : incoming pixel
//   arr_q      : registered window, element 0 in the LSBs
//   arr_d      : value arr_q takes on the next edge
module mfp_window_shreg
  import mfp_row_window_pkg::*;
#(
  parameter int In1W = 8,
  parameter int ArrL = 7
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 load_all,
  input  logic                 shift,
  input  logic                 replicate,
  input  logic [In1W-1:0]      din,
  output logic [In1W*ArrL-1:0] arr_q,
  output logic [In1W*ArrL-1:0] arr_d
);

  logic [In1W-1:0] newest;
  logic [In1W-1:0] shift_din;

  assign newest = arr_q[In1W*ArrL-1 -: In1W];

  // Load-all takes priority over shift; the caller never asserts both.
  always_comb begin
    arr_d     = arr_q;
    shift_din = replicate ? newest : din;
    if (load_all) begin
      arr_d = {ArrL{din}};
    end else if (shift) begin
      arr_d = {shift_din, arr_q[In1W*ArrL-1:In1W]};
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      arr_q <= '0;
    end else begin
      arr_q <= arr_d;
    end
  end

endmodule

// File: rtl/mfp_row_window.sv
// Row window generator: turns a stream of pixels into one ArrL-wide
// window per pixel, with replicate padding at both row borders.
//   clk       : rising-edge clock
//   aclr      : asynchronous active-high clear
//   en        : global enable, freezes everything when low
//   in_valid  : in_data valid
//   in_sol    : start of row, qualified by in_valid
//   in_data   : pixel (In1W bits)
//   in_ready  : en and not flushing (combinational)
//   win_arr   : window, element 0 (LSBs) is the leftmost pixel
//   win_valid : win_arr holds a new window for this enabled cycle
//   win_sol   : window centre is x=0
//   win_eol   : window centre is x=RowL-1
module mfp_row_window
  import mfp_row_window_pkg::*;
#(
  parameter int In1W = 8,
  parameter int ArrL = 7,
  parameter int RowL = 640
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 in_sol,
  input  logic [In1W-1:0]      in_data,
  output logic                 in_ready,
  output logic [In1W*ArrL-1:0] win_arr,
  output logic                 win_valid,
  output logic                 win_sol,
  output logic                 win_eol
);

  localparam int H  = half_len(ArrL);
  localparam int PW = (RowL > 1) ? $clog2(RowL) : 1;
  localparam int FW = (H > 0) ? $clog2(H + 1) : 1;

  localparam logic [PW-1:0] PixHalf = PW'(H);
  localparam logic [PW-1:0] PixFill = PW'(H - 1);
  localparam logic [PW-1:0] PixLast = PW'(RowL - 1);
  localparam logic [FW-1:0] FlLast  = FW'(H - 1);

  row_state_e state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [In1W*ArrL-1:0] win_arr_q, win_arr_d;
  logic win_valid_q, win_valid_d;
  logic win_sol_q, win_sol_d;
  logic win_eol_q, win_eol_d;

  logic accept;
  logic flush_step;
  logic row_start;
  logic emit;
  logic [In1W*ArrL-1:0] shreg_arr;
  logic [In1W*ArrL-1:0] shreg_next;

  assign in_ready   = en && (state_q != ST_FLUSH);
  assign accept     = in_valid && in_ready;
  assign flush_step = en && (state_q == ST_FLUSH);
  // pix_cnt is only zero while waiting for pixel 0, so an explicit
  // in_sol there is harmless; elsewhere it restarts the row.
  assign row_start  = accept && (in_sol || (pix_cnt_q == '0));

  mfp_window_shreg #(
    .In1W(In1W),
    .ArrL(ArrL)
  ) u_shreg (
    .clk      (clk),
    .aclr     (aclr),
    .load_all (row_start),
    .shift    ((accept && !row_start) || flush_step),
    .replicate(flush_step),
    .din      (in_data),
    .arr_q    (shreg_arr),
    .arr_d    (shreg_next)
  );

  // The window register captures the shift register's next value, so a
  // window appears one cycle after the accept or flush step that forms it.
  // Flag outputs are pulses: cleared on every enabled cycle, held when en=0.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    flush_cnt_d = flush_cnt_q;
    win_arr_d   = win_arr_q;
    win_valid_d = win_valid_q;
    win_sol_d   = win_sol_q;
    win_eol_d   = win_eol_q;
    emit        = 1'b0;

    if (en) begin
      win_valid_d = 1'b0;
      win_sol_d   = 1'b0;
      win_eol_d   = 1'b0;
    end

    if (row_start) begin
      pix_cnt_d   = PW'(1);
      flush_cnt_d = '0;
      state_d     = (H <= 1) ? ST_RUN : ST_FILL;
    end else if (accept) begin
      if (pix_cnt_q == PixLast) begin
        pix_cnt_d = '0;
        state_d   = ST_FLUSH;
      end else begin
        pix_cnt_d = pix_cnt_q + PW'(1);
        if ((state_q == ST_FILL) && (pix_cnt_q == PixFill)) begin
          state_d = ST_RUN;
        end
      end
      if (state_q == ST_RUN) begin
        emit      = 1'b1;
        win_sol_d = (pix_cnt_q == PixHalf);
      end
    end else if (flush_step) begin
      emit = 1'b1;
      if (flush_cnt_q == FlLast) begin
        flush_cnt_d = '0;
        state_d     = ST_FILL;
        win_eol_d   = 1'b1;
      end else begin
        flush_cnt_d = flush_cnt_q + FW'(1);
      end
    end

    if (emit) begin
      win_valid_d = 1'b1;
      win_arr_d   = shreg_next;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= ST_FILL;
      pix_cnt_q   <= '0;
      flush_cnt_q <= '0;
      win_arr_q   <= '0;
      win_valid_q <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eol_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      win_arr_q   <= win_arr_d;
      win_valid_q <= win_valid_d;
      win_sol_q   <= win_sol_d;
      win_eol_q   <= win_eol_d;
    end
  end

  assign win_arr   = win_arr_q;
  assign win_valid = win_valid_q;
  assign win_sol   = win_sol_q;
  assign win_eol   = win_eol_q;

  // Present for completeness; the shift register's own output is only
  // observed through win_arr.
  logic unused_shreg;
  assign unused_shreg = ^shreg_arr;

endmodule

// File: tb/tb_mfp_row_window.sv
// Self-checking bench for mfp_row_window with In1W=8, ArrL=7, RowL=8.
module tb_mfp_row_window;

  localparam int In1W = 8;
  localparam int ArrL = 7;
  localparam int RowL = 8;

  logic clk = 1'b0;
  logic aclr;
  logic en;
  logic inValid;
  logic inSol;
  logic [In1W-1:0] inData;
  logic inReady;
  logic [In1W*ArrL-1:0] winArr;
  logic winValid;
  logic winSol;
  logic winEol;

  mfp_row_window #(
    .In1W(In1W),
    .ArrL(ArrL),
    .RowL(RowL)
  ) dut (
    .clk      (clk),
    .aclr     (aclr),
    .en       (en),
    .in_valid (inValid),
    .in_sol   (inSol),
    .in_data  (inData),
    .in_ready (inReady),
    .win_arr  (winArr),
    .win_valid(winValid),
    .win_sol  (winSol),
    .win_eol  (winEol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] arr;
    logic        sol;
    logic        eol;
  } sbEntry_t;

  typedef struct {
    logic [63:0] pix;
    logic        sol0;
    logic [55:0] first;
    logic [55:0] last;
  } rowVec_t;

  sbEntry_t    sbQueue[$];
  logic [55:0] logArr[$];
  int          logCyc[$];
  int          accCycles[8];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;
  logic        lastEn = 1'b0;

  // Cycle counter and record of whether the latest edge was enabled, so a
  // window held through en=0 is only scored once.
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge aclr) begin
    if (aclr) lastEn <= 1'b0;
    else      lastEn <= en;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [55:0] mk7(input logic [7:0] a0, a1, a2, a3, a4, a5, a6);
    return {a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] mk8(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // Expected window for centre x: neighbours clamped to the row borders.
  function automatic sbEntry_t expWin(input logic [63:0] pix, input int x);
    sbEntry_t e;
    int idx;
    e.arr = '0;
    for (int k = 0; k < ArrL; k++) begin
      idx = x - ArrL / 2 + k;
      if (idx < 0) idx = 0;
      if (idx > RowL - 1) idx = RowL - 1;
      e.arr[k*8 +: 8] = pix[idx*8 +: 8];
    end
    e.sol = (x == 0);
    e.eol = (x == RowL - 1);
    return e;
  endfunction

  task automatic pushRow(input logic [63:0] pix);
    for (int x = 0; x < RowL; x++) sbQueue.push_back(expWin(pix, x));
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    sbEntry_t e;
    if (winValid === 1'b1 && lastEn === 1'b1) begin
      logArr.push_back(winArr);
      logCyc.push_back(cyc);
      if (sbQueue.size() == 0) begin
        checkOutput("unexpected_window", {8'h00, winArr}, 64'h0);
        checkOutput("unexpected_window_valid", 64'(winValid), 64'(1'b0));
      end else begin
        e = sbQueue.pop_front();
        checkOutput("win_arr", {8'h00, winArr}, {8'h00, e.arr});
        checkOutput("win_sol", 64'(winSol), 64'(e.sol));
        checkOutput("win_eol", 64'(winEol), 64'(e.eol));
      end
    end
  end

  // Present one pixel and wait until it is accepted; returns #1 after
  // the accepting edge with the cycle number of that edge.
  task automatic applyStimulus(input logic [7:0] d, input logic s, output int accCyc);
    logic rdy;
    logic accepted;
    inValid  = 1'b1;
    inData   = d;
    inSol    = s;
    accepted = 1'b0;
    accCyc   = -1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      rdy = inReady;
      @(posedge clk);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        accCyc   = cyc;
      end
    end
    if (!accepted) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL accept_timeout: pixel %h not accepted within 20 cycles", d);
    end
  endtask

  task automatic driveRow(input logic [63:0] pix, input logic sol0);
    for (int i = 0; i < RowL; i++) begin
      applyStimulus(pix[i*8 +: 8], (i == 0) ? sol0 : 1'b0, accCycles[i]);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
  endtask

  rowVec_t vecs[4];

  initial begin
    int rowAcc0[4];
    int rowAcc7[4];
    int row0Acc3;
    int dummy;
    logic [55:0] holdArr;
    logic holdValid;
    logic [63:0] rowA;
    logic [63:0] rowB;

    vecs[0] = '{mk8(8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17), 1'b1,
                mk7(8'd10, 8'd10, 8'd10, 8'd10, 8'd11, 8'd12, 8'd13),
                mk7(8'd14, 8'd15, 8'd16, 8'd17, 8'd17, 8'd17, 8'd17)};
    vecs[1] = '{mk8(8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27), 1'b0,
                mk7(8'd20, 8'd20, 8'd20, 8'd20, 8'd21, 8'd22, 8'd23),
                mk7(8'd24, 8'd25, 8'd26, 8'd27, 8'd27, 8'd27, 8'd27)};
    vecs[2] = '{mk8(8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF), 1'b1,
                mk7(8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF9, 8'hFA, 8'hFB),
                mk7(8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF)};
    vecs[3] = '{mk8(8'h7F, 8'h80, 8'h00, 8'h01, 8'hFE, 8'h55, 8'hAA, 8'h33), 1'b0,
                mk7(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h00, 8'h01),
                mk7(8'hFE, 8'h55, 8'hAA, 8'h33, 8'h33, 8'h33, 8'h33)};

    // Reset with en low: outputs must clear regardless of enable.
    aclr    = 1'b1;
    en      = 1'b0;
    inValid = 1'b0;
    inSol   = 1'b0;
    inData  = '0;
    #12;
    checkOutput("reset_win_arr", {8'h00, winArr}, 64'h0);
    checkOutput("reset_win_valid", 64'(winValid), 64'h0);
    checkOutput("reset_win_sol", 64'(winSol), 64'h0);
    checkOutput("reset_win_eol", 64'(winEol), 64'h0);
    checkOutput("reset_ready_en0", 64'(inReady), 64'h0);
    en = 1'b1;
    #1;
    checkOutput("reset_ready_en1", 64'(inReady), 64'h1);
    @(negedge clk);
    aclr = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven stream: four rows back-to-back with in_valid held high.
    logArr.delete();
    logCyc.delete();
    row0Acc3 = -1;
    for (int r = 0; r < 4; r++) begin
      pushRow(vecs[r].pix);
      driveRow(vecs[r].pix, vecs[r].sol0);
      rowAcc0[r] = accCycles[0];
      rowAcc7[r] = accCycles[7];
      if (r == 0) row0Acc3 = accCycles[3];
    end
    inValid = 1'b0;
    drain(12);
    checkOutput("stream_window_count", 64'(logArr.size()), 64'(4 * RowL));
    if (logArr.size() >= 4 * RowL) begin
      for (int r = 0; r < 4; r++) begin
        checkOutput($sformatf("row%0d_first", r), {8'h00, logArr[r*RowL]}, {8'h00, vecs[r].first});
        checkOutput($sformatf("row%0d_last", r), {8'h00, logArr[r*RowL+RowL-1]}, {8'h00, vecs[r].last});
      end
      checkOutput("first_win_latency", 64'(logCyc[0]), 64'(row0Acc3));
    end
    for (int r = 1; r < 4; r++) begin
      checkOutput($sformatf("row%0d_restart_gap", r), 64'(rowAcc0[r] - rowAcc7[r-1]), 64'd4);
    end
    checkOutput("stream_sb_drained", 64'(sbQueue.size()), 64'h0);

    // Enable held low for five cycles in the middle of RUN.
    logArr.delete();
    logCyc.delete();
    pushRow(vecs[0].pix);
    for (int i = 0; i < 5; i++) applyStimulus(vecs[0].pix[i*8 +: 8], (i == 0), dummy);
    inValid   = 1'b1;
    inData    = 8'd15;
    inSol     = 1'b0;
    en        = 1'b0;
    holdArr   = winArr;
    holdValid = winValid;
    checkOutput("pause_window_present", 64'(holdValid), 64'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("pause_win_arr", {8'h00, winArr}, {8'h00, holdArr});
      checkOutput("pause_win_valid", 64'(winValid), 64'(holdValid));
      checkOutput("pause_in_ready", 64'(inReady), 64'h0);
      @(posedge clk);
    end
    #1;
    en = 1'b1;
    for (int i = 5; i < RowL; i++) applyStimulus(vecs[0].pix[i*8 +: 8], 1'b0, dummy);
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("flush_ready_%0d", i), 64'(inReady), (i < 3) ? 64'h0 : 64'h1);
    end
    drain(6);
    checkOutput("pause_window_count", 64'(logArr.size()), 64'(RowL));
    checkOutput("pause_sb_drained", 64'(sbQueue.size()), 64'h0);

    // in_sol on the fifth pixel restarts the row with no flush and no eol.
    logArr.delete();
    logCyc.delete();
    rowA = mk8(8'd10, 8'd11, 8'd12, 8'd13, 8'd0, 8'd0, 8'd0, 8'd0);
    rowB = mk8(8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57);
    sbQueue.push_back(expWin(rowA, 0));
    pushRow(rowB);
    for (int i = 0; i < 4; i++) applyStimulus(rowA[i*8 +: 8], (i == 0), dummy);
    driveRow(rowB, 1'b1);
    inValid = 1'b0;
    drain(12);
    checkOutput("sol_window_count", 64'(logArr.size()), 64'(RowL + 1));
    if (logArr.size() >= 2) begin
      checkOutput("sol_restart_first", {8'h00, logArr[1]},
                  {8'h00, mk7(8'd50, 8'd50, 8'd50, 8'd50, 8'd51, 8'd52, 8'd53)});
    end
    checkOutput("sol_sb_drained", 64'(sbQueue.size()), 64'h0);

    // aclr pulse during FLUSH, after one flush window has been produced.
    logArr.delete();
    logCyc.delete();
    pushRow(vecs[0].pix);
    driveRow(vecs[0].pix, 1'b1);
    inValid = 1'b0;
    @(posedge clk);
    #6;
    aclr = 1'b1;
    #1;
    checkOutput("aclr_win_arr", {8'h00, winArr}, 64'h0);
    checkOutput("aclr_win_valid", 64'(winValid), 64'h0);
    checkOutput("aclr_win_sol", 64'(winSol), 64'h0);
    checkOutput("aclr_win_eol", 64'(winEol), 64'h0);
    checkOutput("aclr_windows_before", 64'(logArr.size()), 64'd6);
    checkOutput("aclr_sb_left", 64'(sbQueue.size()), 64'd2);
    sbQueue.delete();
    #2;
    aclr = 1'b0;
    @(negedge clk);
    checkOutput("aclr_ready_after", 64'(inReady), 64'h1);
    @(posedge clk);
    #1;
    logArr.delete();
    logCyc.delete();
    pushRow(vecs[1].pix);
    driveRow(vecs[1].pix, 1'b0);
    inValid = 1'b0;
    drain(12);
    checkOutput("aclr_next_count", 64'(logArr.size()), 64'(RowL));
    if (logArr.size() >= 1) begin
      checkOutput("aclr_next_first", {8'h00, logArr[0]}, {8'h00, vecs[1].first});
    end
    checkOutput("aclr_sb_drained", 64'(sbQueue.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mfp_row_window.md
MFP_ROW_WINDOW -- requirements
Module: mfp_row_window

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; reset polarity and synchronicity are fixed.
REQ-002 Parameter In1W, default 8: pixel width in bits, two's-complement.
REQ-003 Parameter ArrL, default 7: window length; odd values only; H = ArrL/2.
REQ-004 Parameter RowL, default 640: pixels per row; RowL >= ArrL.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 aclr  input  1  asynchronous active-high clear.
REQ-007 en  input  1  global clock enable; when low, all state and outputs are frozen.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_sol  input  1  start-of-row flag, qualified by in_valid.
REQ-010 in_data  input  In1W  pixel.
REQ-011 in_ready  output  1  combinational; equals en AND state != FLUSH.
REQ-012 win_arr  output  In1W*ArrL  window; element 0 (LSBs) is the leftmost pixel; feeds the symmetric MAC In1Arr directly.
REQ-013 win_valid  output  1  win_arr holds a new window for one enabled cycle.
REQ-014 win_sol, win_eol  output  1 each  window centre is x=0 / x=RowL-1.

Function
REQ-015 An accept occurs on a rising clk edge with en=1 and in_valid=1 and in_ready=1.
REQ-016 Each accept and each FLUSH cycle SHALL update an ArrL-deep pixel shift register; the newest pixel enters element ArrL-1.
REQ-017 An accepted pixel 0 of a row SHALL load all ArrL elements with that pixel (left-border replicate).
REQ-018 Each FLUSH cycle SHALL shift in a copy of the newest element (right-border replicate).
REQ-019 States: FILL (pixels 0..H-1 accepted, no output), RUN (pixels H..RowL-1), FLUSH (H cycles, no accepts); encode as 2 bits.
REQ-020 Transitions: FILL->RUN on accept of pixel H-1; RUN->FLUSH on accept of pixel RowL-1; FLUSH->FILL after the H-th flush cycle.
REQ-021 The window for centre x SHALL be registered and presented with win_valid=1 on the cycle after the accept of pixel x+H, or after flush cycle x+H-RowL+1.
REQ-022 Total latency from pixel x+H accept to the window is 1 cycle; each row yields exactly RowL windows.
REQ-023 Input and flush counters SHALL be $clog2(RowL) and $clog2(H+1) bits wide; both wrap to 0 at the end of a row.
REQ-024 An accepted pixel with in_sol=1 in FILL or RUN SHALL be treated as pixel 0 of a new row: the partial row is discarded with no flush and no eol.
REQ-025 in_sol=1 on the expected pixel 0 is a no-op; in_sol is ignored during FLUSH because in_ready=0.
REQ-026 The row-final accept and the first FLUSH cycle SHALL be back-to-back; the next row's pixel 0 SHALL be accepted on the cycle after the last FLUSH cycle.
REQ-027 No arithmetic is performed; pixels pass through bit-exact.

Reset
REQ-028 aclr SHALL force state FILL, all counters 0, all shift-register elements 0, win_arr 0, and win_valid, win_sol and win_eol 0, irrespective of en.
REQ-029 A reset asserted mid-row SHALL discard the row; the first accept after release is pixel 0.

Structure
REQ-030 State encodings (FILL=0, RUN=1, FLUSH=2) SHALL be defined as constants in the shared MFP header alongside the fixed-point primitives.
REQ-031 The shift register with load-all and replicate-shift SHALL be one sub-module, mfp_window_shreg (In1W, ArrL).

Verification (In1W=8, ArrL=7, RowL=8; row pixels 10..17)
REQ-032 Bench SHALL cover: stream the row with in_sol on 10 -> first win_valid the cycle after accepting 13, win_arr {10,10,10,10,11,12,13}, win_sol=1.
REQ-033 Bench SHALL cover: after accepting 17 -> in_ready=0 for exactly 3 cycles; last window {14,15,16,17,17,17,17} with win_eol=1; 8 windows total.
REQ-034 Bench SHALL cover: two rows driven with in_valid held high -> second row's first window {20,20,20,20,21,22,23} follows without gaps; in_ready high again on the cycle after the last flush.
REQ-035 Bench SHALL cover: en=0 for 5 cycles mid-RUN -> win_arr, win_valid and state unchanged and no accepts; resumes identically.
REQ-036 Bench SHALL cover: in_sol=1 on the 5th pixel (value 50) -> no eol emitted; next windows start {50,50,50,50,...}.
REQ-037 Bench SHALL cover: aclr pulse during FLUSH -> all outputs 0 immediately, in_ready=1 after release, next row windows correct.
